// File: rtl/fifo_pkg.sv
// Shared defaults and pointer helper for the flop-based threshold FIFO.
package fifo_pkg;

   localparam int DEF_DEPTH = 8;
   localparam int DEF_BITS  = 16;
   localparam int CNT_W     = $clog2(DEF_DEPTH + 1);

   // Modulo-n increment by explicit compare so non-power-of-2 depths wrap correctly.
   function automatic int unsigned ptr_inc(input int unsigned ptr, input int unsigned n);
      if (ptr == n - 32'd1) begin
         return 32'd0;
      end else begin
         return ptr + 32'd1;
      end
   endfunction

endpackage

// File: rtl/fifo_mem.sv
// Storage array for the FIFO: one synchronous write port, one asynchronous read port.
module fifo_mem
   import fifo_pkg::*;
#(
   parameter int depth = DEF_DEPTH,
   parameter int bits  = DEF_BITS,
   parameter int aw    = 3
) (
   input  logic            clk,
   input  logic            we,
   input  logic [aw-1:0]   waddr,
   input  logic [bits-1:0] wdata,
   input  logic [aw-1:0]   raddr,
   output logic [bits-1:0] rdata
);

   logic [bits-1:0] mem_q [depth];

   // Contents are intentionally left out of reset; pointers/count define validity.
   always_ff @(posedge clk) begin
      if (we) begin
         mem_q[waddr] <= wdata;
      end
   end

   assign rdata = mem_q[raddr];

endmodule

// File: rtl/fifo_flops_thr.sv
// Flop-based FIFO with occupancy count, almost-full/empty thresholds,
// sticky overflow/underflow flags and selectable FWFT or registered read.
module fifo_flops_thr
   import fifo_pkg::*;
#(
   parameter int depth            = DEF_DEPTH,
   parameter int bits             = DEF_BITS,
   parameter int almost_full_thr  = 6,
   parameter int almost_empty_thr = 2,
   parameter int fwft             = 1
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [bits-1:0]              Din,
   input  logic                         push,
   input  logic                         pop,
   input  logic                         clr_err,
   output logic [bits-1:0]              Dout,
   output logic                         full,
   output logic                         pndng,
   output logic [$clog2(depth+1)-1:0]   count,
   output logic                         almost_full,
   output logic                         almost_empty,
   output logic                         overflow,
   output logic                         underflow
);

   localparam int CW = $clog2(depth + 1);
   localparam int AW = (depth > 1) ? $clog2(depth) : 1;

   if (depth < 2 || almost_full_thr < 1 || almost_full_thr > depth ||
       almost_empty_thr < 0 || almost_empty_thr > depth - 1) begin : g_bad_param
      $error("fifo_flops_thr: illegal depth/threshold parameters");
   end

   logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]   count_q, count_d;
   logic            overflow_q, overflow_d, underflow_q, underflow_d;
   logic [bits-1:0] dout_q, dout_d, rdata_s;
   logic            push_acc_s, pop_acc_s;

   fifo_mem #(.depth(depth), .bits(bits), .aw(AW)) u_mem (
      .clk   (clk),
      .we    (push_acc_s),
      .waddr (wr_ptr_q),
      .wdata (Din),
      .raddr (rd_ptr_q),
      .rdata (rdata_s)
   );

   assign full         = (count_q == CW'(depth));
   assign pndng        = (count_q != {CW{1'b0}});
   assign almost_full  = (count_q >= CW'(almost_full_thr));
   assign almost_empty = (count_q <= CW'(almost_empty_thr));
   assign count        = count_q;
   assign overflow     = overflow_q;
   assign underflow    = underflow_q;
   assign Dout         = (fwft != 0) ? (pndng ? rdata_s : {bits{1'b0}}) : dout_q;

   // Accept decisions and next-state for pointers, count, flags and read register.
   always_comb begin
      push_acc_s  = push && (!full || pop);
      pop_acc_s   = pop && pndng;
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      count_d     = count_q;
      overflow_d  = overflow_q;
      underflow_d = underflow_q;
      dout_d      = dout_q;

      if (push_acc_s) begin
         wr_ptr_d = AW'(ptr_inc(32'(wr_ptr_q), depth));
      end else begin
         wr_ptr_d = wr_ptr_q;
      end
      if (pop_acc_s) begin
         rd_ptr_d = AW'(ptr_inc(32'(rd_ptr_q), depth));
      end else begin
         rd_ptr_d = rd_ptr_q;
      end

      if (push_acc_s && !pop_acc_s) begin
         count_d = count_q + CW'(1);
      end else if (pop_acc_s && !push_acc_s) begin
         count_d = count_q - CW'(1);
      end else begin
         count_d = count_q;
      end

      // A fresh error in the clearing cycle takes priority over clr_err.
      if (push && full && !pop) begin
         overflow_d = 1'b1;
      end else if (clr_err) begin
         overflow_d = 1'b0;
      end else begin
         overflow_d = overflow_q;
      end
      if (pop && !pndng) begin
         underflow_d = 1'b1;
      end else if (clr_err) begin
         underflow_d = 1'b0;
      end else begin
         underflow_d = underflow_q;
      end

      if (fwft == 0 && pop_acc_s) begin
         dout_d = rdata_s;
      end else begin
         dout_d = dout_q;
      end
   end

   // State registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q    <= {AW{1'b0}};
         rd_ptr_q    <= {AW{1'b0}};
         count_q     <= {CW{1'b0}};
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
         dout_q      <= {bits{1'b0}};
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         overflow_q  <= overflow_d;
         underflow_q <= underflow_d;
         dout_q      <= dout_d;
      end
   end

endmodule

// File: tb/tb_fifo_flops_thr.sv
// Scoreboard bench: FWFT instance checked by a pop monitor, registered-read instance checked directly.
module tb_fifo_flops_thr;
   import fifo_pkg::*;

   logic              clk, rst;
   logic [15:0]       din, dout, din0, dout0;
   logic              push, pop, clr_err, push0, pop0, clr0;
   logic              full, pndng, af, ae, ovf, unf;
   logic              full0, pndng0, af0, ae0, ovf0, unf0;
   logic [CNT_W-1:0]  count, count0;

   int          n_tests = 0;
   int          n_fail  = 0;
   logic [15:0] exp_q[$];

   fifo_flops_thr #(.depth(8), .bits(16), .almost_full_thr(6), .almost_empty_thr(2), .fwft(1)) u_dut (
      .clk(clk), .rst(rst), .Din(din), .push(push), .pop(pop), .clr_err(clr_err),
      .Dout(dout), .full(full), .pndng(pndng), .count(count), .almost_full(af),
      .almost_empty(ae), .overflow(ovf), .underflow(unf));

   fifo_flops_thr #(.depth(8), .bits(16), .almost_full_thr(6), .almost_empty_thr(2), .fwft(0)) u_dut0 (
      .clk(clk), .rst(rst), .Din(din0), .push(push0), .pop(pop0), .clr_err(clr0),
      .Dout(dout0), .full(full0), .pndng(pndng0), .count(count0), .almost_full(af0),
      .almost_empty(ae0), .overflow(ovf0), .underflow(unf0));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
      end
   endtask

   // One clock of stimulus; x=1 queues the word the accepted pop must present.
   task automatic cyc(input logic p, input logic q, input logic [15:0] d, input logic c,
                      input logic x, input logic [15:0] e);
      push = p; pop = q; din = d; clr_err = c;
      if (x) exp_q.push_back(e);
      @(posedge clk);
      #1;
      push = 1'b0; pop = 1'b0; clr_err = 1'b0;
   endtask

   task automatic cyc0(input logic p, input logic q, input logic [15:0] d);
      push0 = p; pop0 = q; din0 = d;
      @(posedge clk);
      #1;
      push0 = 1'b0; pop0 = 1'b0;
   endtask

   // Monitor: whenever the FWFT FIFO presents a word that is being popped, compare with the queue head.
   always @(negedge clk) begin
      if (!rst && pop && pndng) begin
         if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL pop_unexpected: got 0x%0h, expected no pop data", dout);
         end else begin
            chk("pop_data", {16'h0, dout}, {16'h0, exp_q.pop_front()});
         end
      end
   end

   initial begin
      rst = 1'b1; push = 1'b0; pop = 1'b0; clr_err = 1'b0; din = 16'h0;
      push0 = 1'b0; pop0 = 1'b0; clr0 = 1'b0; din0 = 16'h0;

      // 1: reset
      repeat (2) @(posedge clk);
      #1;
      chk("rst_count", count, 0);
      chk("rst_pndng", pndng, 0);
      chk("rst_full", full, 0);
      chk("rst_ae", ae, 1);
      chk("rst_af", af, 0);
      chk("rst_dout", dout, 0);
      chk("rst_ovf", ovf, 0);
      chk("rst_unf", unf, 0);
      chk("rst_dout0", dout0, 0);
      rst = 1'b0;

      // 2: fill, thresholds, overflow
      for (int i = 1; i <= 8; i++) begin
         cyc(1'b1, 1'b0, 16'(i), 1'b0, 1'b0, 16'h0);
         chk("fill_count", count, i);
         chk("fill_af", af, (i >= 6));
         chk("fill_ae", ae, (i <= 2));
         chk("fill_full", full, (i == 8));
      end
      cyc(1'b1, 1'b0, 16'hDEAD, 1'b0, 1'b0, 16'h0);
      chk("ovf_count", count, 8);
      chk("ovf_flag", ovf, 1);

      // 3: drain in order, then underflow
      for (int i = 1; i <= 8; i++) begin
         cyc(1'b0, 1'b1, 16'h0, 1'b0, 1'b1, 16'(i));
         chk("drain_count", count, 8 - i);
      end
      chk("drain_pndng", pndng, 0);
      chk("drain_dout", dout, 0);
      cyc(1'b0, 1'b1, 16'h0, 1'b0, 1'b0, 16'h0);
      chk("unf_flag", unf, 1);
      chk("unf_count", count, 0);
      cyc(1'b0, 1'b0, 16'h0, 1'b1, 1'b0, 16'h0);
      chk("clr_ovf", ovf, 0);
      chk("clr_unf", unf, 0);

      // push+pop at empty: push taken, pop rejected
      cyc(1'b1, 1'b1, 16'h0077, 1'b0, 1'b0, 16'h0);
      chk("pp_empty_count", count, 1);
      chk("pp_empty_unf", unf, 1);
      chk("pp_empty_dout", dout, 16'h0077);
      cyc(1'b0, 1'b1, 16'h0, 1'b1, 1'b1, 16'h0077);
      chk("pp_empty_drain", count, 0);
      chk("pp_empty_clr", unf, 0);

      // 4: simultaneous push/pop at full
      for (int i = 1; i <= 8; i++) cyc(1'b1, 1'b0, 16'(16'h10 + i), 1'b0, 1'b0, 16'h0);
      cyc(1'b1, 1'b1, 16'h00AA, 1'b0, 1'b1, 16'h0011);
      chk("pp_full_count", count, 8);
      chk("pp_full_full", full, 1);
      chk("pp_full_ovf", ovf, 0);
      for (int i = 2; i <= 8; i++) cyc(1'b0, 1'b1, 16'h0, 1'b0, 1'b1, 16'(16'h10 + i));
      cyc(1'b0, 1'b1, 16'h0, 1'b0, 1'b1, 16'h00AA);
      chk("pp_full_empty", count, 0);

      // 5: 12 push/pop pairs at count 3 (pointer wrap)
      for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 16'(16'h30 + i), 1'b0, 1'b0, 16'h0);
      for (int k = 0; k < 12; k++) begin
         cyc(1'b1, 1'b1, 16'(16'h40 + k), 1'b0, 1'b1,
             (k < 3) ? 16'(16'h30 + k) : 16'(16'h40 + k - 3));
         chk("wrap_count", count, 3);
      end
      for (int i = 9; i < 12; i++) cyc(1'b0, 1'b1, 16'h0, 1'b0, 1'b1, 16'(16'h40 + i));
      chk("wrap_empty", count, 0);
      chk("wrap_unf", unf, 0);

      // 6: clr_err races a new overflow
      for (int i = 1; i <= 8; i++) cyc(1'b1, 1'b0, 16'(16'h60 + i), 1'b0, 1'b0, 16'h0);
      cyc(1'b1, 1'b0, 16'hBEEF, 1'b0, 1'b0, 16'h0);
      chk("ovf2_flag", ovf, 1);
      cyc(1'b1, 1'b0, 16'hC0DE, 1'b1, 1'b0, 16'h0);
      chk("ovf_clr_race", ovf, 1);
      chk("ovf_clr_count", count, 8);
      cyc(1'b0, 1'b0, 16'h0, 1'b1, 1'b0, 16'h0);
      chk("ovf_clr_alone", ovf, 0);
      for (int i = 1; i <= 8; i++) cyc(1'b0, 1'b1, 16'h0, 1'b0, 1'b1, 16'(16'h60 + i));

      // 7: registered read instance
      cyc0(1'b1, 1'b0, 16'h1234);
      chk("reg_pre_pop", dout0, 16'h0000);
      chk("reg_count", count0, 1);
      cyc0(1'b0, 1'b1, 16'h0);
      chk("reg_pop", dout0, 16'h1234);
      cyc0(1'b0, 1'b0, 16'h0);
      cyc0(1'b0, 1'b0, 16'h0);
      chk("reg_hold", dout0, 16'h1234);
      cyc0(1'b1, 1'b0, 16'h5678);
      chk("reg_hold_push", dout0, 16'h1234);
      cyc0(1'b0, 1'b1, 16'h0);
      chk("reg_pop2", dout0, 16'h5678);
      cyc0(1'b0, 1'b1, 16'h0);
      chk("reg_empty_hold", dout0, 16'h5678);
      chk("reg_unf", unf0, 1);

      chk("scoreboard_empty", exp_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
